ipr_nvme_sq_sm: RTL and testbench

//  Submission-side producer: takes one command per valid/ready handshake, writes a 64-byte SQE
//  (16 x 32-bit beats) into SQ buffer RAM, advances admin or IO SQ tail, then requests a tail doorbell write.

---
 rtl/ipr_nvme_sq_sm_pkg.sv | 47 ++++
 rtl/ipr_nvme_sq_sm_sqe_builder.sv | 26 ++
 rtl/ipr_nvme_sq_sm.sv | 179 +++++++++++++++++
 tb/tb_ipr_nvme_sq_sm.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipr_nvme_sq_sm_pkg.sv
// Shared NVMe submission-queue definitions: FSM encoding, opcodes, queue sizes, SQE dword indices.
package ipr_nvme_sq_sm_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'b0001,
    S_WRITE    = 4'b0010,
    S_DOORBELL = 4'b0100,
    S_ERR      = 4'b1000
  } sq_state_e;

  localparam logic [15:0] ADMIN_SIZE_DEF = 16'h000f;
  localparam logic [15:0] IO_SIZE_DEF    = 16'h003f;

  localparam logic [7:0] OPC_ADM_DELETE_IOSQ = 8'h00;
  localparam logic [7:0] OPC_ADM_CREATE_IOSQ = 8'h01;
  localparam logic [7:0] OPC_ADM_CREATE_IOCQ = 8'h05;
  localparam logic [7:0] OPC_ADM_IDENTIFY    = 8'h06;
  localparam logic [7:0] OPC_IO_FLUSH        = 8'h00;
  localparam logic [7:0] OPC_IO_WRITE        = 8'h01;
  localparam logic [7:0] OPC_IO_READ         = 8'h02;

  localparam logic [3:0] DW_CDW0    = 4'd0;
  localparam logic [3:0] DW_NSID    = 4'd1;
  localparam logic [3:0] DW_PRP1_LO = 4'd6;
  localparam logic [3:0] DW_PRP1_HI = 4'd7;
  localparam logic [3:0] DW_PRP2_LO = 4'd8;
  localparam logic [3:0] DW_PRP2_HI = 4'd9;
  localparam logic [3:0] DW_CDW10   = 4'd10;
  localparam logic [3:0] DW_CDW11   = 4'd11;
  localparam logic [3:0] DW_CDW12   = 4'd12;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] cid;
    logic [31:0] nsid;
    logic [63:0] prp1;
    logic [63:0] prp2;
    logic [31:0] cdw10;
    logic [31:0] cdw11;
    logic [31:0] cdw12;
  } sq_cmd_t;

  function automatic logic [15:0] sq_next(input logic [15:0] idx, input logic [15:0] last);
    return (idx == last) ? 16'h0000 : idx + 16'h0001;
  endfunction

endpackage

// File: rtl/ipr_nvme_sq_sm_sqe_builder.sv
// Combinational SQE beat mux: beat index -> 32-bit submission queue entry dword.
module ipr_nvme_sq_sm_sqe_builder
  import ipr_nvme_sq_sm_pkg::*;
(
  input  sq_cmd_t     cmd_i,
  input  logic [3:0]  beat_i,
  output logic [31:0] dw_o
);

  always_comb begin
    dw_o = '0;
    case (beat_i)
      DW_CDW0:    dw_o = {cmd_i.cid, 8'h00, cmd_i.opcode};
      DW_NSID:    dw_o = cmd_i.nsid;
      DW_PRP1_LO: dw_o = cmd_i.prp1[31:0];
      DW_PRP1_HI: dw_o = cmd_i.prp1[63:32];
      DW_PRP2_LO: dw_o = cmd_i.prp2[31:0];
      DW_PRP2_HI: dw_o = cmd_i.prp2[63:32];
      DW_CDW10:   dw_o = cmd_i.cdw10;
      DW_CDW11:   dw_o = cmd_i.cdw11;
      DW_CDW12:   dw_o = cmd_i.cdw12;
      default:    dw_o = '0;
    endcase
  end

endmodule

// File: rtl/ipr_nvme_sq_sm.sv
// NVMe SQ producer: accepts a command, writes its 16-beat SQE into SQ RAM, rings the tail doorbell.
// Define IPR_NVME_SQ_CID_AUTO_EN to take CIDs from per-queue counters instead of cmd_cid_i.
module ipr_nvme_sq_sm
  import ipr_nvme_sq_sm_pkg::*;
#(
  parameter logic [15:0] ADMIN_SIZE = ADMIN_SIZE_DEF,
  parameter logic [15:0] IO_SIZE    = IO_SIZE_DEF
) (
  input  logic        clk_in,
  input  logic        resetb,
  input  logic        is_io_queue_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_opcode_i,
  input  logic [15:0] cmd_cid_i,
  input  logic [31:0] cmd_nsid_i,
  input  logic [63:0] cmd_prp1_i,
  input  logic [63:0] cmd_prp2_i,
  input  logic [31:0] cmd_cdw10_i,
  input  logic [31:0] cmd_cdw11_i,
  input  logic [31:0] cmd_cdw12_i,
  output logic        sqe_wr_en_o,
  output logic [10:0] sqe_wr_addr_o,
  output logic [31:0] sqe_wr_data_o,
  output logic [15:0] asq_tail_out_o,
  output logic        asq_tail_done_o,
  input  logic        asq_tail_done_ack_i,
  output logic [15:0] iosq_tail_out_o,
  output logic        iosq_tail_done_o,
  input  logic        iosq_tail_done_ack_i,
  input  logic        sq_head_valid_i,
  input  logic        sq_head_is_io_i,
  input  logic [15:0] sq_head_in_i,
  output logic        sq_full_o,
  output logic [15:0] admin_submit_cnt_o,
  output logic [31:0] io_submit_cnt_o
);

  sq_state_e   state_q, state_d;
  sq_cmd_t     cmd_q, cmd_d;
  logic        qsel_q, qsel_d;
  logic [5:0]  slot_q, slot_d;
  logic [3:0]  beat_q, beat_d;
  logic [15:0] asq_tail_q, asq_tail_d, iosq_tail_q, iosq_tail_d;
  logic [15:0] asq_head_q, iosq_head_q;
  logic        done_q, done_d;
  logic [15:0] acnt_q, acnt_d;
  logic [31:0] iocnt_q, iocnt_d;
  logic [15:0] cid_sel;
  logic        adm_full, io_full, accept, db_ack, head_err;

`ifdef IPR_NVME_SQ_CID_AUTO_EN
  logic [15:0] acid_q, iocid_q;
  always_ff @(posedge clk_in) begin
    if (resetb) begin
      acid_q  <= '0;
      iocid_q <= '0;
    end else if (accept) begin
      if (is_io_queue_i) iocid_q <= iocid_q + 16'd1;
      else               acid_q  <= acid_q + 16'd1;
    end
  end
  assign cid_sel = is_io_queue_i ? iocid_q : acid_q;
`else
  assign cid_sel = cmd_cid_i;
`endif

  // An out-of-range head is a fatal protocol error; the bad value is never stored.
  assign head_err = sq_head_valid_i &&
                    (sq_head_in_i > (sq_head_is_io_i ? IO_SIZE : ADMIN_SIZE));

  always_ff @(posedge clk_in) begin
    if (resetb) begin
      asq_head_q  <= '0;
      iosq_head_q <= '0;
    end else if (sq_head_valid_i && !head_err) begin
      if (sq_head_is_io_i) iosq_head_q <= sq_head_in_i;
      else                 asq_head_q  <= sq_head_in_i;
    end
  end

  assign adm_full    = sq_next(asq_tail_q, ADMIN_SIZE) == asq_head_q;
  assign io_full     = sq_next(iosq_tail_q, IO_SIZE) == iosq_head_q;
  assign sq_full_o   = is_io_queue_i ? io_full : adm_full;
  assign cmd_ready_o = !resetb && (state_q == S_IDLE) && !sq_full_o;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign db_ack      = qsel_q ? iosq_tail_done_ack_i : asq_tail_done_ack_i;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    qsel_d      = qsel_q;
    slot_d      = slot_q;
    beat_d      = beat_q;
    asq_tail_d  = asq_tail_q;
    iosq_tail_d = iosq_tail_q;
    done_d      = 1'b0;
    acnt_d      = acnt_q;
    iocnt_d     = iocnt_q;
    sqe_wr_en_o = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) begin
        cmd_d   = '{opcode: cmd_opcode_i, cid: cid_sel, nsid: cmd_nsid_i,
                    prp1: cmd_prp1_i, prp2: cmd_prp2_i, cdw10: cmd_cdw10_i,
                    cdw11: cmd_cdw11_i, cdw12: cmd_cdw12_i};
        qsel_d  = is_io_queue_i;
        slot_d  = is_io_queue_i ? iosq_tail_q[5:0] : {2'b00, asq_tail_q[3:0]};
        beat_d  = '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        sqe_wr_en_o = 1'b1;
        beat_d      = beat_q + 4'd1;
        if (beat_q == 4'hf) begin
          if (qsel_q) iosq_tail_d = sq_next(iosq_tail_q, IO_SIZE);
          else        asq_tail_d  = sq_next(asq_tail_q, ADMIN_SIZE);
          state_d = S_DOORBELL;
        end
      end
      S_DOORBELL: begin
        // done rises the cycle after entry and holds until the matching ack
        done_d = 1'b1;
        if (done_q && db_ack) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
          if (qsel_q) iocnt_d = iocnt_q + 32'd1;
          else        acnt_d  = acnt_q + 16'd1;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
    if (head_err) begin
      state_d = S_ERR;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (resetb) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      qsel_q      <= 1'b0;
      slot_q      <= '0;
      beat_q      <= '0;
      asq_tail_q  <= '0;
      iosq_tail_q <= '0;
      done_q      <= 1'b0;
      acnt_q      <= '0;
      iocnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      qsel_q      <= qsel_d;
      slot_q      <= slot_d;
      beat_q      <= beat_d;
      asq_tail_q  <= asq_tail_d;
      iosq_tail_q <= iosq_tail_d;
      done_q      <= done_d;
      acnt_q      <= acnt_d;
      iocnt_q     <= iocnt_d;
    end
  end

  ipr_nvme_sq_sm_sqe_builder u_sqe (
    .cmd_i  (cmd_q),
    .beat_i (beat_q),
    .dw_o   (sqe_wr_data_o)
  );

  assign sqe_wr_addr_o      = {qsel_q, slot_q, beat_q};
  assign asq_tail_out_o     = asq_tail_q;
  assign iosq_tail_out_o    = iosq_tail_q;
  assign asq_tail_done_o    = done_q && !qsel_q;
  assign iosq_tail_done_o   = done_q && qsel_q;
  assign admin_submit_cnt_o = acnt_q;
  assign io_submit_cnt_o    = iocnt_q;

endmodule

// File: tb/tb_ipr_nvme_sq_sm.sv
// Self-checking bench for ipr_nvme_sq_sm: directed scenarios plus randomized commands vs a queue model.
module tb_ipr_nvme_sq_sm;
  logic        clk_in = 1'b0;
  logic        resetb;
  logic        is_io_queue, cmd_valid, cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_cid;
  logic [31:0] cmd_nsid, cmd_cdw10, cmd_cdw11, cmd_cdw12;
  logic [63:0] cmd_prp1, cmd_prp2;
  logic        sqe_wr_en;
  logic [10:0] sqe_wr_addr;
  logic [31:0] sqe_wr_data;
  logic [15:0] asq_tail_out, iosq_tail_out;
  logic        asq_tail_done, asq_tail_done_ack, iosq_tail_done, iosq_tail_done_ack;
  logic        sq_head_valid, sq_head_is_io;
  logic [15:0] sq_head_in;
  logic        sq_full;
  logic [15:0] admin_submit_cnt;
  logic [31:0] io_submit_cnt;

  always #5 clk_in = ~clk_in;

  ipr_nvme_sq_sm dut (
    .clk_in(clk_in), .resetb(resetb), .is_io_queue_i(is_io_queue),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_opcode_i(cmd_opcode),
    .cmd_cid_i(cmd_cid), .cmd_nsid_i(cmd_nsid), .cmd_prp1_i(cmd_prp1), .cmd_prp2_i(cmd_prp2),
    .cmd_cdw10_i(cmd_cdw10), .cmd_cdw11_i(cmd_cdw11), .cmd_cdw12_i(cmd_cdw12),
    .sqe_wr_en_o(sqe_wr_en), .sqe_wr_addr_o(sqe_wr_addr), .sqe_wr_data_o(sqe_wr_data),
    .asq_tail_out_o(asq_tail_out), .asq_tail_done_o(asq_tail_done),
    .asq_tail_done_ack_i(asq_tail_done_ack), .iosq_tail_out_o(iosq_tail_out),
    .iosq_tail_done_o(iosq_tail_done), .iosq_tail_done_ack_i(iosq_tail_done_ack),
    .sq_head_valid_i(sq_head_valid), .sq_head_is_io_i(sq_head_is_io), .sq_head_in_i(sq_head_in),
    .sq_full_o(sq_full), .admin_submit_cnt_o(admin_submit_cnt), .io_submit_cnt_o(io_submit_cnt)
  );

  int checks = 0, failures = 0;
  int unsigned m_tail[2], m_head[2], m_cnt[2];
  logic [15:0] m_cid[2];
  logic [7:0]  c_op;
  logic [15:0] c_cid;
  logic [31:0] c_nsid, c_c10, c_c11, c_c12;
  logic [63:0] c_prp1, c_prp2;
  logic [31:0] exp_dw[16];
  logic [10:0] exp_base;
  logic        cap_en[16];
  logic [10:0] cap_addr[16];
  logic [31:0] cap_data[16];
  logic [15:0] cap_tail;
  int          cap_lat, hold_bad;
  bit          rc_to;
  logic        done_after;

  function automatic int unsigned qsize(input bit q);
    return q ? 63 : 15;
  endfunction
  function automatic bit m_full(input bit q);
    return ((m_tail[q] + 1) % (qsize(q) + 1)) == m_head[q];
  endfunction
  function automatic logic done_of(input bit q);
    return q ? iosq_tail_done : asq_tail_done;
  endfunction
  function automatic logic [15:0] tail_of(input bit q);
    return q ? iosq_tail_out : asq_tail_out;
  endfunction
  function automatic logic [31:0] cnt_of(input bit q);
    return q ? io_submit_cnt : {16'h0, admin_submit_cnt};
  endfunction

  task automatic do_reset;
    resetb = 1'b1; cmd_valid = 0; asq_tail_done_ack = 0; iosq_tail_done_ack = 0;
    sq_head_valid = 0; sq_head_is_io = 0; sq_head_in = 0; is_io_queue = 0;
    repeat (2) @(negedge clk_in);
    resetb = 1'b0;
    for (int q = 0; q < 2; q++) begin m_tail[q] = 0; m_head[q] = 0; m_cnt[q] = 0; m_cid[q] = 0; end
  endtask

  task automatic rand_fields;
    c_op = 8'($urandom); c_cid = 16'($urandom); c_nsid = $urandom;
    c_prp1 = {$urandom, $urandom}; c_prp2 = {$urandom, $urandom};
    c_c10 = $urandom; c_c11 = $urandom; c_c12 = $urandom;
  endtask

  task automatic head_upd(input bit q, input logic [15:0] v);
    sq_head_valid = 1; sq_head_is_io = q; sq_head_in = v;
    @(negedge clk_in);
    sq_head_valid = 0;
    if (v <= qsize(q)) m_head[q] = v;
  endtask

  // Drives one command through accept, 16 beats and doorbell; captures observations for the caller.
  task automatic run_cmd(input bit q, input int ack_dly);
    int n;
    logic [15:0] cid;
    rc_to = 0; hold_bad = 0;
    is_io_queue = q; cmd_opcode = c_op; cmd_cid = c_cid; cmd_nsid = c_nsid;
    cmd_prp1 = c_prp1; cmd_prp2 = c_prp2; cmd_cdw10 = c_c10; cmd_cdw11 = c_c11; cmd_cdw12 = c_c12;
    #1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 300) begin @(negedge clk_in); #1; n++; end
    if (n >= 300) rc_to = 1;
`ifdef IPR_NVME_SQ_CID_AUTO_EN
    cid = m_cid[q];
`else
    cid = c_cid;
`endif
    m_cid[q] = m_cid[q] + 16'd1;
    exp_base = {q, 6'(m_tail[q]), 4'h0};
    for (int k = 0; k < 16; k++) exp_dw[k] = '0;
    exp_dw[0] = {cid, 8'h00, c_op}; exp_dw[1] = c_nsid;
    exp_dw[6] = c_prp1[31:0]; exp_dw[7] = c_prp1[63:32];
    exp_dw[8] = c_prp2[31:0]; exp_dw[9] = c_prp2[63:32];
    exp_dw[10] = c_c10; exp_dw[11] = c_c11; exp_dw[12] = c_c12;
    cmd_valid = 1;
    @(posedge clk_in); #1 cmd_valid = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_in);
      cap_en[k] = sqe_wr_en; cap_addr[k] = sqe_wr_addr; cap_data[k] = sqe_wr_data;
    end
    m_tail[q] = (m_tail[q] + 1) % (qsize(q) + 1);
    n = 0;
    do begin @(negedge clk_in); n++; end while (done_of(q) !== 1'b1 && n < 40);
    cap_lat = n;
    if (n >= 40) rc_to = 1;
    cap_tail = tail_of(q);
    for (int d = 0; d < ack_dly; d++) begin
      cmd_valid = 1;
      if (q) asq_tail_done_ack = 1; else iosq_tail_done_ack = 1;
      @(negedge clk_in);
      if (done_of(q) !== 1'b1 || cmd_ready !== 1'b0 || sqe_wr_en !== 1'b0) hold_bad++;
    end
    cmd_valid = 0; asq_tail_done_ack = 0; iosq_tail_done_ack = 0;
    if (q) iosq_tail_done_ack = 1; else asq_tail_done_ack = 1;
    @(negedge clk_in);
    asq_tail_done_ack = 0; iosq_tail_done_ack = 0;
    done_after = done_of(q);
    m_cnt[q]++;
  endtask

  task automatic test_reset;
    resetb = 1'b1; cmd_valid = 0; asq_tail_done_ack = 0; iosq_tail_done_ack = 0;
    sq_head_valid = 0; sq_head_is_io = 0; sq_head_in = 0; is_io_queue = 0;
    cmd_opcode = 0; cmd_cid = 0; cmd_nsid = 0; cmd_prp1 = 0; cmd_prp2 = 0;
    cmd_cdw10 = 0; cmd_cdw11 = 0; cmd_cdw12 = 0;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({sqe_wr_en, asq_tail_done, iosq_tail_done, cmd_ready, sq_full} !== 5'b0 ||
        sqe_wr_addr !== 11'h0 || sqe_wr_data !== 32'h0 || asq_tail_out !== 16'h0 ||
        iosq_tail_out !== 16'h0 || admin_submit_cnt !== 16'h0 || io_submit_cnt !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs en=%b done=%b/%b rdy=%b full=%b tails=%h/%h cnt=%h/%h required all zero",
               sqe_wr_en, asq_tail_done, iosq_tail_done, cmd_ready, sq_full,
               asq_tail_out, iosq_tail_out, admin_submit_cnt, io_submit_cnt);
    end
    resetb = 1'b0;
    for (int q = 0; q < 2; q++) begin m_tail[q] = 0; m_head[q] = 0; m_cnt[q] = 0; m_cid[q] = 0; end
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || sq_full !== 1'b0) begin
      failures++; $display("FAIL reset_ready got rdy=%b full=%b required rdy=1 full=0", cmd_ready, sq_full);
    end
  endtask

  task automatic test_admin_single;
    do_reset();
    rand_fields(); c_op = 8'h06; c_cid = 16'h0001;
    run_cmd(0, 0);
    checks++;
    if (rc_to || cap_lat !== 2) begin
      failures++; $display("FAIL single_done_latency got=%0d timeout=%0b required=2", cap_lat, rc_to);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cap_en[k] !== 1'b1 || cap_addr[k] !== 11'(k) || cap_data[k] !== exp_dw[k]) begin
        failures++;
        $display("FAIL single_beat%0d got en=%b addr=%h data=%h required en=1 addr=%h data=%h",
                 k, cap_en[k], cap_addr[k], cap_data[k], 11'(k), exp_dw[k]);
      end
    end
    checks++;
    if (cap_data[0] !== 32'h0001_0006) begin
      failures++; $display("FAIL single_dw0 got=%h required=00010006", cap_data[0]);
    end
    checks++;
    if (cap_tail !== 16'd1 || admin_submit_cnt !== 16'd1 || done_after !== 1'b0 || iosq_tail_out !== 16'd0) begin
      failures++;
      $display("FAIL single_doorbell got tail=%h cnt=%h done=%b iotail=%h required tail=1 cnt=1 done=0 iotail=0",
               cap_tail, admin_submit_cnt, done_after, iosq_tail_out);
    end
  endtask

  task automatic test_admin_wrap;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rand_fields();
      run_cmd(0, 0);
      head_upd(0, 16'(m_tail[0]));
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cap_addr[k] !== 11'h0f0 + 11'(k) || cap_data[k] !== exp_dw[k]) begin
        failures++;
        $display("FAIL wrap_beat%0d got addr=%h data=%h required addr=%h data=%h",
                 k, cap_addr[k], cap_data[k], 11'h0f0 + 11'(k), exp_dw[k]);
      end
    end
    checks++;
    if (cap_tail !== 16'd0 || admin_submit_cnt !== 16'd16) begin
      failures++; $display("FAIL wrap_tail got tail=%h cnt=%0d required tail=0 cnt=16", cap_tail, admin_submit_cnt);
    end
  endtask

  task automatic test_io_full;
    int bad;
    do_reset();
    for (int i = 0; i < 63; i++) begin rand_fields(); run_cmd(1, 0); end
    is_io_queue = 1; #1;
    checks++;
    if (sq_full !== 1'b1 || cmd_ready !== 1'b0 || iosq_tail_out !== 16'd63 || io_submit_cnt !== 32'd63) begin
      failures++;
      $display("FAIL io_full got full=%b rdy=%b tail=%0d cnt=%0d required full=1 rdy=0 tail=63 cnt=63",
               sq_full, cmd_ready, iosq_tail_out, io_submit_cnt);
    end
    is_io_queue = 0; #1;
    checks++;
    if (sq_full !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL io_full_admin_side got full=%b rdy=%b required full=0 rdy=1", sq_full, cmd_ready);
    end
    is_io_queue = 1; cmd_valid = 1; bad = 0;
    repeat (3) begin @(negedge clk_in); if (sqe_wr_en !== 1'b0) bad++; end
    cmd_valid = 0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL io_full_no_accept got %0d write beats required 0", bad); end
    sq_head_valid = 1; sq_head_is_io = 1; sq_head_in = 16'd5; #1;
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL io_head_same_cycle got rdy=%b required 0", cmd_ready); end
    @(negedge clk_in);
    sq_head_valid = 0; m_head[1] = 5; #1;
    checks++;
    if (cmd_ready !== 1'b1 || sq_full !== 1'b0) begin
      failures++; $display("FAIL io_head_next_cycle got rdy=%b full=%b required rdy=1 full=0", cmd_ready, sq_full);
    end
    rand_fields();
    run_cmd(1, 0);
    checks++;
    if (cap_addr[0] !== 11'h7f0 || cap_data[0] !== exp_dw[0] || cap_tail !== 16'd0) begin
      failures++; $display("FAIL io_slot63 got addr=%h tail=%h required addr=7f0 tail=0", cap_addr[0], cap_tail);
    end
  endtask

  task automatic test_ack_holdoff;
    do_reset();
    rand_fields();
    run_cmd(1, 10);
    checks++;
    if (hold_bad != 0 || rc_to || cap_lat !== 2) begin
      failures++; $display("FAIL holdoff_done got bad_cycles=%0d lat=%0d required bad=0 lat=2", hold_bad, cap_lat);
    end
    checks++;
    if (io_submit_cnt !== 32'd1 || admin_submit_cnt !== 16'd0 || done_after !== 1'b0) begin
      failures++;
      $display("FAIL holdoff_count got io=%0d adm=%0d done=%b required io=1 adm=0 done=0",
               io_submit_cnt, admin_submit_cnt, done_after);
    end
    iosq_tail_done_ack = 1; asq_tail_done_ack = 1;
    repeat (5) @(negedge clk_in);
    iosq_tail_done_ack = 0; asq_tail_done_ack = 0;
    checks++;
    if (io_submit_cnt !== 32'd1 || admin_submit_cnt !== 16'd0 || iosq_tail_done !== 1'b0) begin
      failures++; $display("FAIL stray_ack got io=%0d adm=%0d required io=1 adm=0", io_submit_cnt, admin_submit_cnt);
    end
  endtask

  task automatic test_reset_midburst;
    int n, bad;
    do_reset();
    rand_fields();
    is_io_queue = 0; cmd_opcode = c_op; cmd_cid = c_cid; #1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk_in); #1; n++; end
    cmd_valid = 1;
    @(posedge clk_in); #1 cmd_valid = 0;
    repeat (8) @(negedge clk_in);
    checks++;
    if (sqe_wr_en !== 1'b1 || sqe_wr_addr !== 11'h007) begin
      failures++; $display("FAIL midburst_beat7 got en=%b addr=%h required en=1 addr=007", sqe_wr_en, sqe_wr_addr);
    end
    resetb = 1'b1;
    @(negedge clk_in);
    checks++;
    if (sqe_wr_en !== 1'b0 || asq_tail_out !== 16'd0 || iosq_tail_out !== 16'd0) begin
      failures++; $display("FAIL midburst_reset got en=%b tail=%h required en=0 tail=0", sqe_wr_en, asq_tail_out);
    end
    resetb = 1'b0; bad = 0;
    for (int q = 0; q < 2; q++) begin m_tail[q] = 0; m_head[q] = 0; m_cnt[q] = 0; m_cid[q] = 0; end
    repeat (20) begin
      @(negedge clk_in);
      if (asq_tail_done !== 1'b0 || iosq_tail_done !== 1'b0 || sqe_wr_en !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || admin_submit_cnt !== 16'd0) begin
      failures++; $display("FAIL midburst_after got bad_cycles=%0d cnt=%0d required 0/0", bad, admin_submit_cnt);
    end
  endtask

  task automatic test_head_err;
    int bad;
    do_reset();
    head_upd(0, 16'h000f);
    head_upd(1, 16'h003f);
    is_io_queue = 0; #1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL head_max_admin got rdy=%b required 1", cmd_ready); end
    is_io_queue = 1; #1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL head_max_io got rdy=%b required 1", cmd_ready); end
    head_upd(0, 16'h0020);
    bad = 0; cmd_valid = 1;
    for (int i = 0; i < 20; i++) begin
      is_io_queue = i[0]; #1;
      if (cmd_ready !== 1'b0) bad++;
      @(negedge clk_in);
      if (sqe_wr_en !== 1'b0) bad++;
    end
    cmd_valid = 0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL head_err_sticky got %0d ready/write cycles required 0", bad); end
    do_reset(); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL head_err_reset got rdy=%b required 1", cmd_ready); end
    head_upd(1, 16'h0040);
    is_io_queue = 1; #1;
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL head_err_io got rdy=%b required 0", cmd_ready); end
  endtask

  task automatic test_random;
    bit q;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        q = 1'($urandom);
        head_upd(q, 16'($urandom_range(0, qsize(q))));
      end
      q = 1'($urandom);
      if (m_full(q)) begin
        is_io_queue = q; #1;
        checks++;
        if (sq_full !== 1'b1 || cmd_ready !== 1'b0) begin
          failures++; $display("FAIL rand_full q=%0d got full=%b rdy=%b required full=1 rdy=0", q, sq_full, cmd_ready);
        end
        head_upd(q, 16'(m_tail[q]));
      end
      rand_fields();
      run_cmd(q, $urandom_range(0, 3));
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (cap_en[k] !== 1'b1 || cap_addr[k] !== exp_base + 11'(k) || cap_data[k] !== exp_dw[k]) begin
          failures++;
          $display("FAIL rand%0d_beat%0d got en=%b addr=%h data=%h required addr=%h data=%h",
                   i, k, cap_en[k], cap_addr[k], cap_data[k], exp_base + 11'(k), exp_dw[k]);
        end
      end
      checks++;
      if (rc_to || cap_lat !== 2 || hold_bad != 0 || done_after !== 1'b0 ||
          cap_tail !== 16'(m_tail[q]) || cnt_of(q) !== m_cnt[q]) begin
        failures++;
        $display("FAIL rand%0d_doorbell q=%0d got lat=%0d tail=%0d cnt=%0d hold_bad=%0d required lat=2 tail=%0d cnt=%0d",
                 i, q, cap_lat, cap_tail, cnt_of(q), hold_bad, m_tail[q], m_cnt[q]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_admin_single();
    test_admin_wrap();
    test_io_full();
    test_ack_holdoff();
    test_reset_midburst();
    test_head_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
